// File: rtl/grf_mp_bypass.sv
// grf_mp_bypass: multi-read-port general register file with two prioritised
// write ports, optional same-cycle write-to-read bypass and a per-register
// busy scoreboard for the hazard unit.
module grf_mp_bypass #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic [31:0]              wr0_pc,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [31:0]              wr1_pc,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [2**ADDR_W-1:0]     busy
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  // Power-up contents are zero even without a reset edge.
  logic [DATA_W-1:0] regs_q [DEPTH] = '{default: '0};
  logic [DEPTH-1:0]  busy_q = '0;
  logic [DEPTH-1:0]  busy_d;

  logic wr0_commit;
  logic wr1_commit;

  // Port 1 wins a same-address collision; register 0 is read-only when hardwired.
  always_comb begin
    wr1_commit = wr1_en && !(ZERO_REG && (wr1_addr == '0));
    wr0_commit = wr0_en && !(ZERO_REG && (wr0_addr == '0))
                        && !(wr1_en && (wr1_addr == wr0_addr));
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    if (ZERO_REG && (a == '0))
      return '0;
    else if (BYPASS && wr1_en && (wr1_addr == a))
      return wr1_data;
    else if (BYPASS && wr0_en && (wr0_addr == a))
      return wr0_data;
    else
      return regs_q[a];
  endfunction

  // Combinational read ports; busy flags come from the registered scoreboard only.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_data[k*DATA_W +: DATA_W] = read_port(rd_addr[k*ADDR_W +: ADDR_W]);
      rd_busy[k]                  = busy_q[rd_addr[k*ADDR_W +: ADDR_W]];
    end
  end

  // Register array update; reset discards any write in the same cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      if (wr0_commit) regs_q[wr0_addr] <= wr0_data;
      if (wr1_commit) regs_q[wr1_addr] <= wr1_data;
    end
  end

  // Scoreboard next state: clears from committed writes, then issue set overrides.
  always_comb begin
    busy_d = busy_q;
    if (wr0_commit) busy_d[wr0_addr] = 1'b0;
    if (wr1_commit) busy_d[wr1_addr] = 1'b0;
    if (iss_en)     busy_d[iss_addr] = 1'b1;
    if (ZERO_REG)   busy_d[0]        = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge Clk) begin
    if (Reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy = busy_q;

`ifndef SYNTHESIS
  // Commit trace, port 0 first; dropped, ignored or reset-cancelled writes are silent.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (wr0_commit) $display("@%h: $%d <= %h", wr0_pc, wr0_addr, wr0_data);
      if (wr1_commit) $display("@%h: $%d <= %h", wr1_pc, wr1_addr, wr1_data);
    end
  end
`endif

endmodule

// File: tb/tb_grf_mp_bypass.sv
// Self-checking bench for grf_mp_bypass: directed scenarios followed by random
// traffic, all compared against an array-based reference model.
module tb_grf_mp_bypass;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned D  = 32;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             wr0_en, wr1_en, iss_en;
  logic [AW-1:0]    wr0_addr, wr1_addr, iss_addr;
  logic [DW-1:0]    wr0_data, wr1_data;
  logic [31:0]      wr0_pc, wr1_pc;
  logic [D-1:0]     busy;

  grf_mp_bypass #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1'b1), .ZERO_REG(1'b1)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_pc(wr0_pc),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_pc(wr1_pc),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] mem [D];
  logic [D-1:0]  bm;

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (a == 0)                      return '0;
    if (wr1_en && wr1_addr == a)     return wr1_data;
    if (wr0_en && wr0_addr == a)     return wr0_data;
    return mem[a];
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0; wr0_pc = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0; wr1_pc = '0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Check all outputs against the model, then clock once and advance the model.
  task automatic tick();
    logic [AW-1:0] a;
    #1;
    for (int k = 0; k < int'(NR); k++) begin
      a = rd_addr[k*AW +: AW];
      check($sformatf("rd_data%0d", k), rd_data[k*DW +: DW], model_read(a));
      check($sformatf("rd_busy%0d", k), {31'b0, rd_busy[k]}, {31'b0, bm[a]});
    end
    check("busy", busy, bm);
    @(posedge Clk);
    if (Reset) begin
      for (int i = 0; i < int'(D); i++) mem[i] = '0;
      bm = '0;
    end else begin
      // Later write overrides earlier one: port 1 has priority.
      if (wr0_en && wr0_addr != 0) begin mem[wr0_addr] = wr0_data; bm[wr0_addr] = 1'b0; end
      if (wr1_en && wr1_addr != 0) begin mem[wr1_addr] = wr1_data; bm[wr1_addr] = 1'b0; end
      if (iss_en) bm[iss_addr] = 1'b1;
      bm[0] = 1'b0;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < int'(D); i++) mem[i] = '0;
    bm = '0;
    idle();
    set_rd('0, '0);
    Reset = 1'b1;

    // Reset, then sweep every register on both ports
    tick();
    Reset = 1'b0;
    check("reset_busy", busy, '0);
    for (int r = 0; r < int'(D); r++) begin
      set_rd(AW'(r), AW'(D - 1 - r));
      tick();
    end

    // Bypass on port 0 write, then stored value
    set_rd(5'd5, 5'd0);
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF; wr0_pc = 32'h100;
    #1 check("t2_bypass", rd_data[31:0], 32'hDEADBEEF);
    tick();
    idle();
    #1 check("t2_stored", rd_data[31:0], 32'hDEADBEEF);
    tick();

    // Same-address collision: port 1 wins
    set_rd(5'd7, 5'd7);
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11; wr0_pc = 32'h104;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22; wr1_pc = 32'h108;
    #1 check("t3_bypass", rd_data[63:32], 32'h22);
    tick();
    idle();
    #1 check("t3_stored", rd_data[31:0], 32'h22);
    tick();

    // Register 0 ignores writes and issues
    set_rd(5'd0, 5'd0);
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF; wr1_pc = 32'h10C;
    iss_en = 1'b1; iss_addr = 5'd0;
    #1 check("t4_zero_rd", rd_data[31:0], 32'h0);
    tick();
    idle();
    #1 check("t4_zero_busy", {31'b0, busy[0]}, 32'h0);
    tick();

    // Scoreboard: set, set-beats-clear, clear one cycle later
    set_rd(5'd9, 5'd9);
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    idle();
    #1 check("t5_set", {31'b0, rd_busy[0]}, 32'h1);
    iss_en = 1'b1; iss_addr = 5'd9;
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h99; wr0_pc = 32'h110;
    tick();
    idle();
    #1 check("t5_set_wins", {31'b0, busy[9]}, 32'h1);
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h9A; wr0_pc = 32'h114;
    #1 check("t5_no_bypass", {31'b0, rd_busy[1]}, 32'h1);
    tick();
    idle();
    #1 check("t5_cleared", {31'b0, rd_busy[0]}, 32'h0);
    tick();

    // Reset cancels a same-cycle write
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h5; wr0_pc = 32'h118;
    iss_en = 1'b1; iss_addr = 5'd3;
    tick();
    idle();
    set_rd(5'd3, 5'd3);
    wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h9; wr1_pc = 32'h11C;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    idle();
    #1 check("t6_data", rd_data[31:0], 32'h0);
    check("t6_busy", {31'b0, rd_busy[1]}, 32'h0);
    tick();

    // Random traffic, biased toward low addresses to provoke collisions
    for (int n = 0; n < 600; n++) begin
      logic lo;
      lo = 1'($urandom_range(0, 1));
      Reset    = ($urandom_range(0, 59) == 0);
      wr0_en   = 1'($urandom_range(0, 1));
      wr1_en   = 1'($urandom_range(0, 1));
      iss_en   = 1'($urandom_range(0, 1));
      wr0_addr = lo ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
      wr1_addr = lo ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
      iss_addr = lo ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
      wr0_data = $urandom;
      wr1_data = $urandom;
      wr0_pc   = 32'(n * 8);
      wr1_pc   = 32'(n * 8 + 4);
      set_rd(lo ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31)),
             lo ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31)));
      tick();
    end
    Reset = 1'b0;
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
